// File: rtl/bk_sector_seq.sv
// bk_sector_seq: walks SECTORS consecutive hps_io sector transfers for one
// save slot, either reading (load) or writing (save), paced by sd_ack.
module bk_sector_seq #(
  parameter int SECTORS = 64,
  parameter int SLOT_W  = 2,
  parameter int LBA_W   = 32
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              bk_ena,
  input  logic              load_req,
  input  logic              save_req,
  input  logic [SLOT_W-1:0] slot,
  output logic [LBA_W-1:0]  sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  output logic              busy,
  output logic              loading,
  output logic              done,
  output logic              aborted
);

  localparam int IDX_W = $clog2(SECTORS);
  localparam int BASE_W = SLOT_W + IDX_W;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LBA_W-1:0]   lba_q, lba_d;
  logic               rd_q, rd_d, wr_q, wr_d;
  logic               busy_q, busy_d, loading_q, loading_d;
  logic               done_q, done_d, aborted_q, aborted_d;
  logic               ld_q, ld_d, sv_q, sv_d, ack_q, ack_d;

  logic               start_ld, start_sv, ack_rise, ack_fall;
  logic [BASE_W-1:0]  base;

  // SECTORS is a power of two, so slot*SECTORS is the slot with zero index bits
  assign base     = {slot, {IDX_W{1'b0}}};
  assign start_ld = load_req & bk_ena & ~ld_q;
  assign start_sv = save_req & bk_ena & ~sv_q;
  assign ack_rise = sd_ack & ~ack_q;
  assign ack_fall = ~sd_ack & ack_q;

  // Next-state: request edges start a sequence, ack edges pace each sector
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lba_d     = lba_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    busy_d    = busy_q;
    loading_d = loading_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    ld_d      = load_req & bk_ena;
    sv_d      = save_req & bk_ena;
    ack_d     = sd_ack;
    case (state_q)
      IDLE: begin
        if (start_ld || start_sv) begin
          // load takes priority when both edges arrive together
          idx_d     = '0;
          lba_d     = LBA_W'(base);
          rd_d      = start_ld;
          wr_d      = ~start_ld;
          busy_d    = 1'b1;
          loading_d = start_ld;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (ack_fall) begin
          if (idx_q == IDX_W'(SECTORS - 1)) begin
            busy_d    = 1'b0;
            loading_d = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else if (!bk_ena) begin
            // image went away: stop cleanly between sectors
            busy_d    = 1'b0;
            loading_d = 1'b0;
            aborted_d = 1'b1;
            state_d   = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            lba_d   = lba_q + LBA_W'(1);
            rd_d    = loading_q;
            wr_d    = ~loading_q;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      lba_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      ld_q      <= 1'b0;
      sv_q      <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lba_q     <= lba_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      loading_q <= loading_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      ld_q      <= ld_d;
      sv_q      <= sv_d;
      ack_q     <= ack_d;
    end
  end

  assign sd_lba  = lba_q;
  assign sd_rd   = rd_q;
  assign sd_wr   = wr_q;
  assign busy    = busy_q;
  assign loading = loading_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_bk_sector_seq.sv
// Bench for bk_sector_seq: hps_io ack responder, sequence-level reference
// model compared every cycle, directed scenarios plus randomized traffic.
module tb_bk_sector_seq;
  localparam int SECTORS = 64;
  localparam int SLOT_W  = 2;
  localparam int LBA_W   = 32;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              bk_ena = 1'b1;
  logic              load_req = 1'b0;
  logic              save_req = 1'b0;
  logic [SLOT_W-1:0] slot = '0;
  logic              sd_ack = 1'b0;
  logic [LBA_W-1:0]  sd_lba;
  logic              sd_rd, sd_wr, busy, loading, done, aborted;

  always #5 clk_sys = ~clk_sys;

  bk_sector_seq #(.SECTORS(SECTORS), .SLOT_W(SLOT_W), .LBA_W(LBA_W)) dut (
    .clk_sys(clk_sys), .reset(reset), .bk_ena(bk_ena), .load_req(load_req),
    .save_req(save_req), .slot(slot), .sd_lba(sd_lba), .sd_rd(sd_rd),
    .sd_wr(sd_wr), .sd_ack(sd_ack), .busy(busy), .loading(loading),
    .done(done), .aborted(aborted)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (sequence level) ----------------
  // A sequence is: a base LBA, a sector number, a mode, and whether the
  // current sector's request is still waiting for hps_io to pick it up.
  typedef struct {
    bit busy, load, req, done, abort;
    bit p_ld, p_sv, p_ack;
    int base, sec;
  } model_t;

  model_t m = '{default: 0};

  function automatic model_t step(model_t s, bit rst, bit ena, bit lr, bit sr,
                                  bit ack, int sl);
    model_t n;
    bit go_ld, go_sv, a_rise, a_fall;
    n = s;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    go_ld  = lr && ena && !s.p_ld;
    go_sv  = sr && ena && !s.p_sv;
    a_rise = ack && !s.p_ack;
    a_fall = !ack && s.p_ack;
    n.done  = 0;
    n.abort = 0;
    if (!s.busy) begin
      if (go_ld || go_sv) begin
        n.busy = 1; n.load = go_ld; n.req = 1;
        n.base = sl * SECTORS; n.sec = 0;
      end
    end else if (s.req) begin
      if (a_rise) n.req = 0;
    end else if (a_fall) begin
      if (s.sec == SECTORS - 1) begin
        n.busy = 0; n.load = 0; n.done = 1;
      end else if (!ena) begin
        n.busy = 0; n.load = 0; n.abort = 1;
      end else begin
        n.sec = s.sec + 1; n.req = 1;
      end
    end
    n.p_ld  = lr && ena;
    n.p_sv  = sr && ena;
    n.p_ack = ack;
    return n;
  endfunction

  always @(posedge clk_sys)
    m <= step(m, reset, bk_ena, load_req, save_req, sd_ack, int'(slot));

  function automatic logic [LBA_W-1:0] exp_lba(model_t s);
    longint v;
    v = longint'(s.base) + longint'(s.sec);
    return v[LBA_W-1:0];
  endfunction

  // every-cycle comparison against the model
  always @(negedge clk_sys) begin
    chk("ctl{rd,wr,busy,loading,done,aborted}",
        {58'd0, sd_rd, sd_wr, busy, loading, done, aborted},
        {58'd0, m.req & m.load, m.req & ~m.load, m.busy, m.load, m.done, m.abort});
    chk("sd_lba", {32'd0, sd_lba}, {32'd0, exp_lba(m)});
  end

  // ---------------- activity statistics from the DUT pins ----------------
  int rd_p = 0, wr_p = 0, done_n = 0, abort_n = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  logic [LBA_W-1:0] last_lba = '0;

  always @(negedge clk_sys) begin
    prev_rd <= sd_rd;
    prev_wr <= sd_wr;
    if (sd_rd && !prev_rd) begin rd_p <= rd_p + 1; last_lba <= sd_lba; end
    if (sd_wr && !prev_wr) begin wr_p <= wr_p + 1; last_lba <= sd_lba; end
    if (done) done_n <= done_n + 1;
    if (aborted) abort_n <= abort_n + 1;
  end

  // ---------------- hps_io responder ----------------
  int h_dly = 3, h_len = 5, h_wait = 0, h_left = 0;
  bit h_rand = 0, h_active = 0, glitch_en = 0;

  always @(negedge clk_sys) begin
    if (h_active) begin
      if (h_left <= 1) begin sd_ack <= 1'b0; h_active <= 0; h_wait <= 0; end
      else h_left <= h_left - 1;
    end else if (sd_rd || sd_wr) begin
      if (h_wait >= h_dly) begin
        sd_ack   <= 1'b1;
        h_active <= 1;
        h_left   <= h_rand ? int'($urandom_range(1, 6)) : h_len;
      end else h_wait <= h_wait + 1;
    end else begin
      h_wait <= 0;
      if (glitch_en && $urandom_range(0, 15) == 0) begin
        sd_ack <= 1'b1; h_active <= 1; h_left <= 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk_sys); n++; end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", budget);
    end
  endtask

  task automatic wait_sector_xfer(input int sec, input int budget);
    int n = 0;
    while (!(m.busy && !m.req && m.sec == sec && sd_ack) && n < budget) begin
      @(negedge clk_sys); n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_xfer: sector %0d transfer not reached in %0d cycles", sec, budget);
    end
  endtask

  int rd0, wr0, dn0, ab0;
  task automatic snap();
    cyc(1);
    rd0 = rd_p; wr0 = wr_p; dn0 = done_n; ab0 = abort_n;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset lba", {32'd0, sd_lba}, 64'd0);
    chk("reset rd/wr", {62'd0, sd_rd, sd_wr}, 64'd0);
    reset = 1'b0;
    cyc(2);

    // load, slot 2, fixed 3/5 ack timing
    snap();
    slot = 2; load_req = 1'b1;
    cyc(1);
    chk("load first rd", {63'd0, sd_rd}, 64'd1);
    chk("load first lba", {32'd0, sd_lba}, 64'd128);
    chk("load loading", {63'd0, loading}, 64'd1);
    cyc(1); load_req = 1'b0;
    wait_idle(3000); cyc(2);
    chk("load rd pulses", 64'(rd_p - rd0), 64'd64);
    chk("load wr pulses", 64'(wr_p - wr0), 64'd0);
    chk("load last lba", {32'd0, last_lba}, 64'd191);
    chk("load done pulses", 64'(done_n - dn0), 64'd1);

    // save, slot 0
    snap();
    slot = 0; save_req = 1'b1;
    cyc(2); save_req = 1'b0;
    wait_idle(3000); cyc(2);
    chk("save wr pulses", 64'(wr_p - wr0), 64'd64);
    chk("save rd pulses", 64'(rd_p - rd0), 64'd0);
    chk("save last lba", {32'd0, last_lba}, 64'd63);
    chk("save done pulses", 64'(done_n - dn0), 64'd1);

    // simultaneous request edges: load wins
    slot = 1; load_req = 1'b1; save_req = 1'b1;
    cyc(1);
    chk("both rd", {63'd0, sd_rd}, 64'd1);
    chk("both wr", {63'd0, sd_wr}, 64'd0);
    chk("both lba", {32'd0, sd_lba}, 64'd64);
    cyc(1); load_req = 1'b0; save_req = 1'b0;
    wait_idle(3000); cyc(2);

    // request gated by bk_ena, then bk_ena rises under a held request; slot wrap
    snap();
    bk_ena = 1'b0; slot = 3; load_req = 1'b1;
    cyc(5);
    chk("gated busy", {63'd0, busy}, 64'd0);
    chk("gated rd pulses", 64'(rd_p - rd0), 64'd0);
    bk_ena = 1'b1;
    cyc(1);
    chk("ena-rise rd", {63'd0, sd_rd}, 64'd1);
    chk("ena-rise lba", {32'd0, sd_lba}, 64'd192);
    load_req = 1'b0;
    wait_idle(3000); cyc(2);
    chk("wrap last lba", {32'd0, last_lba}, 64'd255);
    chk("wrap done pulses", 64'(done_n - dn0), 64'd1);

    // bk_ena drops during sector 10
    snap();
    slot = 1; load_req = 1'b1;
    cyc(2); load_req = 1'b0;
    wait_sector_xfer(10, 2000);
    bk_ena = 1'b0;
    wait_idle(100); cyc(2);
    chk("abort pulses", 64'(abort_n - ab0), 64'd1);
    chk("abort done pulses", 64'(done_n - dn0), 64'd0);
    chk("abort rd pulses", 64'(rd_p - rd0), 64'd11);
    chk("abort last lba", {32'd0, last_lba}, 64'd74);
    bk_ena = 1'b1;
    cyc(3);

    // reset during sector 30, then restart; save edges while busy are dropped
    slot = 2; load_req = 1'b1;
    cyc(2); load_req = 1'b0;
    wait_sector_xfer(30, 2000);
    reset = 1'b1;
    cyc(1);
    chk("mid-reset busy", {63'd0, busy}, 64'd0);
    chk("mid-reset lba", {32'd0, sd_lba}, 64'd0);
    chk("mid-reset loading", {63'd0, loading}, 64'd0);
    reset = 1'b0;
    snap();
    load_req = 1'b1;
    cyc(1);
    chk("restart rd", {63'd0, sd_rd}, 64'd1);
    chk("restart lba", {32'd0, sd_lba}, 64'd128);
    load_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(7); save_req = 1'b1; cyc(2); save_req = 1'b0;
    end
    wait_idle(3000); cyc(2);
    chk("restart wr pulses", 64'(wr_p - wr0), 64'd0);
    chk("restart rd pulses", 64'(rd_p - rd0), 64'd64);
    chk("restart done pulses", 64'(done_n - dn0), 64'd1);

    // randomized traffic: timing, slot churn, request churn, ena drops, ack glitches
    h_rand = 1; glitch_en = 1;
    for (int it = 0; it < 8; it++) begin
      int n;
      h_dly = $urandom_range(0, 4);
      slot = SLOT_W'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) load_req = 1'b1; else save_req = 1'b1;
      cyc(1);
      n = 0;
      while (busy && n < 4000) begin
        @(negedge clk_sys); n++;
        if ($urandom_range(0, 7) == 0) slot = SLOT_W'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) load_req = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) save_req = 1'($urandom_range(0, 1));
        bk_ena = ($urandom_range(0, 399) != 0);
      end
      load_req = 1'b0; save_req = 1'b0; bk_ena = 1'b1;
      wait_idle(4000);
      cyc(3);
    end
    glitch_en = 0;
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bk_sector_seq.md
Name: bk_sector_seq

Overview:
- Sequences save-state transfers between the backup RAM and the mounted save image through the hps_io SD sector interface.
- A load or save request issues SECTORS consecutive sector requests (sd_rd or sd_wr), starting at slot*SECTORS.
- Each request is paced by the sd_ack handshake.
- While a load runs, `loading` holds the system in reset; `busy` drives the user LED.

Parameters:
- SECTORS, 64, sectors per slot; power of 2, minimum 2.
- SLOT_W, 2, width of the slot select.
- LBA_W, 32, width of sd_lba.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- bk_ena  in  1  save image mounted and writable; gates new requests.
- load_req  in  1  level request; its rising edge starts a load.
- save_req  in  1  level request; its rising edge starts a save.
- slot  in  SLOT_W  slot number, sampled at start.
- sd_lba  out  LBA_W  sector address presented to hps_io.
- sd_rd  out  1  sector read request.
- sd_wr  out  1  sector write request.
- sd_ack  in  1  hps_io acknowledge, high while a sector is being transferred.
- busy  out  1  a transfer sequence is active.
- loading  out  1  the active sequence is a load.
- done  out  1  one-cycle pulse when all SECTORS sectors have completed.
- aborted  out  1  one-cycle pulse when a sequence ends early because bk_ena dropped.

Behaviour:
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, busy=0, loading=0, done=0, aborted=0, state=IDLE, sector index=0, all edge registers=0.
- Reset asserted mid-sequence: all of the above take effect on the next edge; the in-flight hps_io sector is abandoned.
- Request edge detection:
  - ld_d <= load_req & bk_ena; sv_d <= save_req & bk_ena.
  - start_ld = load_req & bk_ena & ~ld_d; start_sv likewise.
  - A request held high across bk_ena rising does start a sequence.
- ack_d <= sd_ack. ack_rise = sd_ack & ~ack_d; ack_fall = ~sd_ack & ack_d.
- IDLE:
  - On start_ld or start_sv, all in the same edge:
    - latch mode; load wins if both fire in the same cycle;
    - idx <= 0;
    - sd_lba <= slot*SECTORS, zero-extended to LBA_W;
    - sd_rd <= load; sd_wr <= ~load;
    - busy <= 1; loading <= load; go to REQ.
  - Outputs are therefore visible one cycle after the request first samples high.
  - Request edges are not queued while busy.
- REQ:
  - On ack_rise: sd_rd <= 0, sd_wr <= 0; go to XFER.
  - Otherwise hold the request indefinitely; there is no timeout.
- XFER, on ack_fall:
  - idx == SECTORS-1: go to IDLE; busy <= 0, loading <= 0, done <= 1 for one cycle.
  - Otherwise, if bk_ena == 0: go to IDLE; busy <= 0, loading <= 0, aborted <= 1 for one cycle.
  - Otherwise: idx <= idx+1; sd_lba <= sd_lba+1; reassert sd_rd or sd_wr per mode; go to REQ.
  - The next request is therefore issued the cycle after sd_ack is first seen low.
- bk_ena dropping during REQ or XFER: the current sector completes normally; the abort is evaluated only at ack_fall.
- slot changes while busy have no effect. sd_lba never leaves [slot*SECTORS, slot*SECTORS+SECTORS-1].
- Slot wrap: slot at its maximum with SECTORS=64 gives a base of 192; the final LBA is 255, with no carry into bit 8.
- sd_rd and sd_wr are never high together. Neither is high outside REQ.
- An sd_ack glitch in IDLE is ignored. An ack_fall in REQ, with no preceding rise, is ignored.

Test Plan:
- Load, slot=2, SECTORS=64, hps model acks 3 cycles after request for 5 cycles:
  - sd_rd pulses 64 times; sd_lba runs 128..191; sd_wr stays 0.
  - loading=1 throughout; one done pulse; busy falls in the same cycle as done.
- Save, slot=0:
  - sd_wr pulses 64 times; sd_lba runs 0..63; loading stays 0; done pulses once.
- load_req and save_req rise in the same cycle, slot=1:
  - load mode; first sd_lba=64; sd_rd=1; sd_wr=0.
- bk_ena=0 while load_req rises:
  - no activity.
  - bk_ena then rises with load_req still high: sequence starts with first sd_lba=slot*64.
- bk_ena dropped during the sector-10 transfer:
  - sector 10 completes; no sector-11 request.
  - aborted pulses once; done never asserts; busy=0.
- Reset asserted in XFER at sector 30, then load_req re-pulsed:
  - outputs return to reset values the next cycle.
  - the new sequence restarts at sector 0 of the latched slot.
  - save_req pulses during busy do not start a second sequence.
